// File: rtl/cell_alloc_arbiter.sv
// cell_alloc_arbiter
// Round-robin arbiter sharing the single cell-allocator port among
// REQ_PORT_NUM requesters. Each port carries an outstanding-cell quota that is
// charged on a successful grant and credited by rel_valid. While the allocator
// reports memory pressure only ports in prio_mask are eligible.
// Optional build macro CELL_ALLOC_ARB_STATS_EN adds saturating grant/fail
// statistics counters as extra outputs.
module cell_alloc_arbiter #(
    parameter int REQ_PORT_NUM  = 4,
    parameter int LEN_WIDTH     = 16,
    parameter int CELL_NUM      = 64,
    parameter int CELL_ID_WIDTH = $clog2(CELL_NUM),
    parameter int PORT_QUOTA    = 16,
    parameter int CNT_WIDTH     = $clog2(PORT_QUOTA + 1)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [REQ_PORT_NUM-1:0]           req_valid,
    output logic [REQ_PORT_NUM-1:0]           req_ready,
    input  logic [REQ_PORT_NUM*LEN_WIDTH-1:0] req_size,
    output logic [REQ_PORT_NUM-1:0]           resp_valid,
    output logic                              resp_success,
    output logic [CELL_ID_WIDTH-1:0]          resp_cell_id,
    input  logic [REQ_PORT_NUM-1:0]           prio_mask,
    input  logic [REQ_PORT_NUM-1:0]           rel_valid,
    output logic [REQ_PORT_NUM*CNT_WIDTH-1:0] outstanding,
    output logic                              underflow_err,
`ifdef CELL_ALLOC_ARB_STATS_EN
    output logic [31:0]                       stat_grant_count,
    output logic [31:0]                       stat_fail_count,
`endif
    output logic                              alloc_mem_req,
    output logic [LEN_WIDTH-1:0]              alloc_mem_size,
    input  logic [CELL_ID_WIDTH-1:0]          alloc_cell_id,
    input  logic                              alloc_mem_success,
    input  logic                              alloc_mem_intense
);

    localparam int IDX_W = $clog2(REQ_PORT_NUM);
    localparam logic [IDX_W:0]          NPORT_C    = (IDX_W + 1)'(REQ_PORT_NUM);
    localparam logic [IDX_W-1:0]        LAST_IDX_C = IDX_W'(REQ_PORT_NUM - 1);
    localparam logic [IDX_W-1:0]        IDX_ONE_C  = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0]    QUOTA_C    = CNT_WIDTH'(PORT_QUOTA);
    localparam logic [CNT_WIDTH-1:0]    CNT_ONE_C  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0]    CNT_ZERO_C = {CNT_WIDTH{1'b0}};
    localparam logic [REQ_PORT_NUM-1:0] ONEHOT0_C  = {{(REQ_PORT_NUM-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t                    state_r;
    state_t                    state_nxt_s;
    logic [IDX_W-1:0]          ptr_r;
    logic [IDX_W-1:0]          win_r;
    logic [IDX_W-1:0]          pick_s;
    logic                      found_s;
    logic [IDX_W:0]            scan_s;
    logic [REQ_PORT_NUM-1:0]   elig_s;
    logic [REQ_PORT_NUM-1:0]   inc_s;
    logic [CNT_WIDTH-1:0]      cnt_r [REQ_PORT_NUM];
    logic                      mem_req_r;
    logic [LEN_WIDTH-1:0]      mem_size_r;
    logic [REQ_PORT_NUM-1:0]   resp_valid_r;
    logic                      resp_success_r;
    logic [CELL_ID_WIDTH-1:0]  resp_cell_id_r;
    logic                      underflow_r;

    assign alloc_mem_req  = mem_req_r;
    assign alloc_mem_size = mem_size_r;
    assign resp_valid     = resp_valid_r;
    assign req_ready      = resp_valid_r;
    assign resp_success   = resp_success_r;
    assign resp_cell_id   = resp_cell_id_r;
    assign underflow_err  = underflow_r;

    // Per-port eligibility: requesting, below quota, and allowed under pressure.
    always_comb begin
        elig_s = {REQ_PORT_NUM{1'b0}};
        for (int i = 0; i < REQ_PORT_NUM; i++) begin
            elig_s[i] = req_valid[i] && (cnt_r[i] < QUOTA_C) &&
                        (!alloc_mem_intense || prio_mask[i]);
        end
    end

    // Round-robin scan: first eligible port at or after the pointer, wrapping.
    always_comb begin
        found_s = 1'b0;
        pick_s  = {IDX_W{1'b0}};
        scan_s  = {(IDX_W+1){1'b0}};
        for (int k = 0; k < REQ_PORT_NUM; k++) begin
            scan_s = {1'b0, ptr_r} + (IDX_W + 1)'(k);
            if (scan_s >= NPORT_C) begin
                scan_s = scan_s - NPORT_C;
            end else begin
                scan_s = scan_s;
            end
            if (!found_s && elig_s[scan_s[IDX_W-1:0]]) begin
                found_s = 1'b1;
                pick_s  = scan_s[IDX_W-1:0];
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next-state logic for the IDLE -> ISSUE -> RESP grant sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (found_s) begin
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: state_nxt_s = ST_RESP;
            ST_RESP:  state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // State register plus registered allocator request and response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            ptr_r          <= {IDX_W{1'b0}};
            win_r          <= {IDX_W{1'b0}};
            mem_req_r      <= 1'b0;
            mem_size_r     <= {LEN_WIDTH{1'b0}};
            resp_valid_r   <= {REQ_PORT_NUM{1'b0}};
            resp_success_r <= 1'b0;
            resp_cell_id_r <= {CELL_ID_WIDTH{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            case (state_r)
                ST_IDLE: begin
                    if (found_s) begin
                        win_r      <= pick_s;
                        mem_req_r  <= 1'b1;
                        mem_size_r <= req_size[pick_s*LEN_WIDTH +: LEN_WIDTH];
                    end else begin
                        mem_req_r  <= 1'b0;
                        mem_size_r <= {LEN_WIDTH{1'b0}};
                    end
                end
                ST_ISSUE: begin
                    mem_req_r      <= 1'b0;
                    mem_size_r     <= {LEN_WIDTH{1'b0}};
                    resp_valid_r   <= ONEHOT0_C << win_r;
                    resp_success_r <= alloc_mem_success;
                    resp_cell_id_r <= alloc_mem_success ? alloc_cell_id
                                                        : {CELL_ID_WIDTH{1'b0}};
                end
                ST_RESP: begin
                    resp_valid_r   <= {REQ_PORT_NUM{1'b0}};
                    resp_success_r <= 1'b0;
                    resp_cell_id_r <= {CELL_ID_WIDTH{1'b0}};
                    ptr_r          <= (win_r == LAST_IDX_C) ? {IDX_W{1'b0}}
                                                            : win_r + IDX_ONE_C;
                end
                default: begin
                    mem_req_r      <= 1'b0;
                    mem_size_r     <= {LEN_WIDTH{1'b0}};
                    resp_valid_r   <= {REQ_PORT_NUM{1'b0}};
                    resp_success_r <= 1'b0;
                    resp_cell_id_r <= {CELL_ID_WIDTH{1'b0}};
                end
            endcase
        end
    end

    // Quota charge strobe: the winner of a successful RESP cycle.
    always_comb begin
        inc_s = {REQ_PORT_NUM{1'b0}};
        for (int i = 0; i < REQ_PORT_NUM; i++) begin
            inc_s[i] = (state_r == ST_RESP) && resp_success_r && (win_r == IDX_W'(i));
        end
    end

    // Outstanding counters and sticky underflow flag; a charge and a release
    // landing together cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REQ_PORT_NUM; i++) begin
                cnt_r[i] <= CNT_ZERO_C;
            end
            underflow_r <= 1'b0;
        end else begin
            for (int i = 0; i < REQ_PORT_NUM; i++) begin
                if (inc_s[i] && !rel_valid[i]) begin
                    cnt_r[i] <= cnt_r[i] + CNT_ONE_C;
                end else if (!inc_s[i] && rel_valid[i]) begin
                    if (cnt_r[i] != CNT_ZERO_C) begin
                        cnt_r[i] <= cnt_r[i] - CNT_ONE_C;
                    end else begin
                        underflow_r <= 1'b1;
                    end
                end else begin
                    cnt_r[i] <= cnt_r[i];
                end
            end
        end
    end

    // Flatten the counter array onto the outstanding bus.
    always_comb begin
        outstanding = {(REQ_PORT_NUM*CNT_WIDTH){1'b0}};
        for (int i = 0; i < REQ_PORT_NUM; i++) begin
            outstanding[i*CNT_WIDTH +: CNT_WIDTH] = cnt_r[i];
        end
    end

`ifdef CELL_ALLOC_ARB_STATS_EN
    logic [31:0] grant_cnt_r;
    logic [31:0] fail_cnt_r;

    assign stat_grant_count = grant_cnt_r;
    assign stat_fail_count  = fail_cnt_r;

    // Saturating counts of successful and failed response cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt_r <= 32'd0;
            fail_cnt_r  <= 32'd0;
        end else if (state_r == ST_RESP) begin
            if (resp_success_r && (grant_cnt_r != 32'hFFFF_FFFF)) begin
                grant_cnt_r <= grant_cnt_r + 32'd1;
            end else if (!resp_success_r && (fail_cnt_r != 32'hFFFF_FFFF)) begin
                fail_cnt_r <= fail_cnt_r + 32'd1;
            end else begin
                grant_cnt_r <= grant_cnt_r;
            end
        end else begin
            grant_cnt_r <= grant_cnt_r;
        end
    end
`endif

endmodule

// File: tb/tb_cell_alloc_arbiter.sv
// Directed testbench for cell_alloc_arbiter (4 ports, quota 2).
module tb_cell_alloc_arbiter;

    localparam int N  = 4;
    localparam int LW = 16;
    localparam int CW = 2;
    localparam int IW = 6;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*LW-1:0] req_size;
    logic [N-1:0]    resp_valid;
    logic            resp_success;
    logic [IW-1:0]   resp_cell_id;
    logic [N-1:0]    prio_mask;
    logic [N-1:0]    rel_valid;
    logic [N*CW-1:0] outstanding;
    logic            underflow_err;
    logic            alloc_mem_req;
    logic [LW-1:0]   alloc_mem_size;
    logic [IW-1:0]   alloc_cell_id;
    logic            alloc_mem_success;
    logic            alloc_mem_intense;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int req_cnt = 0;
    int resp_cnt = 0;
    logic [LW-1:0] last_size = 16'd0;
    int prev_cyc;
    int snap;

    cell_alloc_arbiter #(
        .REQ_PORT_NUM(N), .LEN_WIDTH(LW), .CELL_NUM(64), .PORT_QUOTA(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_size(req_size),
        .resp_valid(resp_valid), .resp_success(resp_success),
        .resp_cell_id(resp_cell_id), .prio_mask(prio_mask),
        .rel_valid(rel_valid), .outstanding(outstanding),
        .underflow_err(underflow_err), .alloc_mem_req(alloc_mem_req),
        .alloc_mem_size(alloc_mem_size), .alloc_cell_id(alloc_cell_id),
        .alloc_mem_success(alloc_mem_success),
        .alloc_mem_intense(alloc_mem_intense)
    );

    always #5 clk = ~clk;

    // Cycle counter and allocator-side activity monitor.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (alloc_mem_req) begin
            req_cnt   <= req_cnt + 1;
            last_size <= alloc_mem_size;
        end
        if (resp_valid != 4'd0) resp_cnt <= resp_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a response and check its contents.
    task automatic expect_resp(input string tag, input int port, input logic succ,
                               input logic [IW-1:0] id, input logic [LW-1:0] size);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (resp_valid == 4'd0 && n < 20);
        check_eq({tag, " resp_valid"}, 32'(resp_valid), 32'd1 << port);
        check_eq({tag, " req_ready"}, 32'(req_ready), 32'd1 << port);
        check_eq({tag, " success"}, 32'(resp_success), 32'(succ));
        check_eq({tag, " cell_id"}, 32'(resp_cell_id), 32'(id));
        check_eq({tag, " mem_size"}, 32'(last_size), 32'(size));
    endtask

    task automatic pulse_rel(input logic [N-1:0] mask);
        rel_valid = mask;
        @(negedge clk);
        rel_valid = 4'd0;
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 4'd0;
        req_size = {16'd400, 16'd300, 16'd200, 16'd100};
        prio_mask = 4'd0;
        rel_valid = 4'd0;
        alloc_cell_id = 6'd10;
        alloc_mem_success = 1'b1;
        alloc_mem_intense = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst resp_valid", 32'(resp_valid), 32'd0);
        check_eq("rst req_ready", 32'(req_ready), 32'd0);
        check_eq("rst mem_req", 32'(alloc_mem_req), 32'd0);
        check_eq("rst mem_size", 32'(alloc_mem_size), 32'd0);
        check_eq("rst outstanding", 32'(outstanding), 32'd0);
        check_eq("rst underflow", 32'(underflow_err), 32'd0);
        check_eq("rst cell_id", 32'(resp_cell_id), 32'd0);

        // Round robin with all ports requesting.
        rst_n = 1'b1;
        req_valid = 4'hF;
        prev_cyc = 0;
        for (int g = 0; g < 4; g++) begin
            expect_resp($sformatf("rr%0d", g), g, 1'b1, 6'(10 + g), 16'(100 * (g + 1)));
            if (g > 0) check_eq($sformatf("rr%0d gap", g), 32'(cyc - prev_cyc), 32'd3);
            prev_cyc = cyc;
            alloc_cell_id = 6'(11 + g);
        end
        @(negedge clk);
        check_eq("rr outstanding x4", 32'(outstanding), 32'h55);
        expect_resp("rr4", 0, 1'b1, 6'd14, 16'd100);
        check_eq("rr4 gap", 32'(cyc - prev_cyc), 32'd3);
        req_valid = 4'd0;
        @(negedge clk);
        check_eq("rr outstanding x5", 32'(outstanding), 32'h56);
        pulse_rel(4'hF);
        pulse_rel(4'h1);
        check_eq("rel outstanding", 32'(outstanding), 32'd0);
        check_eq("rel underflow", 32'(underflow_err), 32'd0);

        // Quota: port 1 alone, quota 2.
        alloc_cell_id = 6'd15;
        req_valid = 4'b0010;
        expect_resp("q0", 1, 1'b1, 6'd15, 16'd200);
        alloc_cell_id = 6'd16;
        expect_resp("q1", 1, 1'b1, 6'd16, 16'd200);
        alloc_cell_id = 6'd17;
        snap = req_cnt;
        repeat (8) @(negedge clk);
        check_eq("quota held req", 32'(req_cnt - snap), 32'd0);
        check_eq("quota outstanding", 32'(outstanding), 32'h08);
        prev_cyc = cyc;
        pulse_rel(4'b0010);
        expect_resp("q2", 1, 1'b1, 6'd17, 16'd200);
        check_eq("quota latency", 32'(cyc - prev_cyc), 32'd3);
        req_valid = 4'd0;
        @(negedge clk);
        check_eq("quota outstanding2", 32'(outstanding), 32'h08);
        check_eq("quota req count", 32'(req_cnt - snap), 32'd1);
        pulse_rel(4'b0010);
        pulse_rel(4'b0010);

        // Failed allocation; pointer must still advance (ptr=2).
        alloc_cell_id = 6'd7;
        alloc_mem_success = 1'b0;
        req_valid = 4'b0101;
        expect_resp("fail", 2, 1'b0, 6'd0, 16'd300);
        alloc_mem_success = 1'b1;
        expect_resp("after fail", 0, 1'b1, 6'd7, 16'd100);
        req_valid = 4'd0;
        @(negedge clk);
        check_eq("fail outstanding", 32'(outstanding), 32'h01);

        // Memory pressure masking (ptr=1).
        alloc_cell_id = 6'd8;
        alloc_mem_intense = 1'b1;
        prio_mask = 4'b0100;
        req_valid = 4'b0101;
        expect_resp("intense0", 2, 1'b1, 6'd8, 16'd300);
        alloc_cell_id = 6'd9;
        expect_resp("intense1", 2, 1'b1, 6'd9, 16'd300);
        alloc_mem_intense = 1'b0;
        alloc_cell_id = 6'd10;
        expect_resp("intense off", 0, 1'b1, 6'd10, 16'd100);
        req_valid = 4'd0;
        @(negedge clk);
        check_eq("intense outstanding", 32'(outstanding), 32'h22);

        // Underflow and same-cycle charge/release.
        pulse_rel(4'b1000);
        check_eq("underflow set", 32'(underflow_err), 32'd1);
        check_eq("underflow count", 32'(outstanding), 32'h22);
        repeat (3) @(negedge clk);
        check_eq("underflow sticky", 32'(underflow_err), 32'd1);
        pulse_rel(4'b0001);
        check_eq("pre-cancel outstanding", 32'(outstanding), 32'h21);
        alloc_cell_id = 6'd11;
        req_valid = 4'b0001;
        expect_resp("cancel", 0, 1'b1, 6'd11, 16'd100);
        req_valid = 4'd0;
        pulse_rel(4'b0001);
        check_eq("cancel outstanding", 32'(outstanding), 32'h21);

        // Asynchronous reset during ISSUE.
        req_valid = 4'b0010;
        for (int n = 0; n < 10 && !alloc_mem_req; n++) @(negedge clk);
        check_eq("issue reached", 32'(alloc_mem_req), 32'd1);
        snap = resp_cnt;
        #1 rst_n = 1'b0;
        #1;
        check_eq("async mem_req", 32'(alloc_mem_req), 32'd0);
        check_eq("async outstanding", 32'(outstanding), 32'd0);
        check_eq("async underflow", 32'(underflow_err), 32'd0);
        req_valid = 4'd0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("abort no resp", 32'(resp_cnt - snap), 32'd0);
        check_eq("post rst outstanding", 32'(outstanding), 32'd0);
        check_eq("post rst mem_req", 32'(alloc_mem_req), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
